instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer in front of the instruction memory (sync ROM, 1-cycle read latency, word = A[8:2]).
//  Owns the PC: issues byte addresses, pairs returned words with their PC, hands them to decode over valid/ready.
//  Handles decode back-pressure, execute-stage redirects, halt requests and misaligned-target faults.
// PARAMETERS
//  ADDR_W    32         PC / byte-address width
//  INSTR_W   32         instruction width
//  RESET_PC  32'h0      first address fetched after reset
// PORTS
//  clk             in   1        single clock, rising edge
//  rst             in   1        async reset, active-low
//  imem_addr       out  ADDR_W   byte address to instruction memory (combinational, see below)
//  imem_rdata      in   INSTR_W  word for address presented on previous edge
//  redirect_valid  in   1        branch/jump taken this cycle
//  redirect_pc     in   ADDR_W   redirect target
//  halt_req        in   1        level: stop fetching while high
//  fetch_valid     out  1        fetch_instr/fetch_pc valid
//  fetch_ready     in   1        decode accepts this cycle
//  fetch_instr     out  INSTR_W  = imem_rdata (pass-through)
//  fetch_pc        out  ADDR_W   PC of fetch_instr
//  halted          out  1        state HALTED
//  fetch_err       out  1        sticky: misaligned redirect seen
//  perf_fetched    out  32       accepted-instruction count (see CONFIGURATION)
//  perf_stalls     out  32       back-pressure cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Regs: pc_q (next addr to issue), f2_valid, f2_pc (addr issued last edge), state.
//  Reset (rst=0): pc_q=RESET_PC, f2_valid=0, f2_pc=0, state=RUN; outputs: fetch_valid=0, halted=0, fetch_err=0,
//   imem_addr=RESET_PC, counters=0. First fetch_valid on 2nd rising edge after rst release.
//  stall = f2_valid & ~fetch_ready; accept = fetch_valid & fetch_ready.
//  fetch_valid = f2_valid & ~redirect_valid & (state!=ERR).  fetch_pc = f2_pc.
//  imem_addr priority: redirect_valid -> redirect_pc; stall -> f2_pc (re-read keeps ROM q stable);
//   else pc_q.
//  FSM RUN:
//   redirect_valid & redirect_pc[1:0]!=0 -> ERR (f2_valid<=0).
//   redirect_valid (aligned): f2_pc<=redirect_pc, f2_valid<=1, pc_q<=redirect_pc+4; F2 word squashed;
//    redirect wins over stall and halt_req.
//   stall: all regs hold.
//   halt_req & ~stall -> DRAIN: no new issue, f2_valid<=0, pc_q holds.
//   else: f2_pc<=pc_q, f2_valid<=1, pc_q<=pc_q+4.
//  DRAIN: single cycle -> HALTED (f2_valid already 0). HALTED: halted=1, imem_addr=pc_q;
//   halt_req=0 -> RUN (resumes at pc_q, no instruction lost/duplicated). Redirect in HALTED updates pc_q only.
//  ERR: fetch_err=1, fetch_valid=0, all inputs ignored until rst.
//  PC arithmetic modulo 2^ADDR_W; wrap from all-ones word to 0 silent. Memory aliasing above 512 B not flagged.
//  halt_req during stall: held instruction must be accepted first, then DRAIN.
// CONFIGURATION
//  IFETCH_PERF_CNT_EN defined: perf_fetched += 1 on each accept; perf_stalls += 1 each stall cycle;
//   both saturate at 32'hFFFF_FFFF, reset to 0.
//  Not defined: perf_fetched/perf_stalls tied 0, no counter flops.
// STRUCTURE
//  Package ifetch_pkg: fetch_state_e {RUN, DRAIN, HALTED, ERR}, PC_STEP=4, ALIGN_MASK=2'b11.
//  Sub-module ifetch_perf_cnt (saturating counter pair), instantiated only under IFETCH_PERF_CNT_EN.
// TESTING
//  1 Reset release, fetch_ready=1 -> imem_addr 0,4,8..; fetch_pc 0,4,8 one per cycle from 2nd edge.
//  2 fetch_ready=0 for 3 cycles at fetch_pc=8 -> imem_addr=8, fetch_pc/instr stable 3 cycles; then 12 next.
//  3 redirect_valid, redirect_pc=0x40 while fetch_pc=0x10 valid -> fetch_valid=0 that cycle; next fetch_pc=0x40, then 0x44.
//  4 halt_req=1 at pc_q=0x20 -> DRAIN, halted=1 next cycle; release -> fetch_pc resumes 0x20.
//  5 redirect_pc=0x42 -> fetch_err=1, fetch_valid=0 sticky; mid-op rst=0 clears, restarts at RESET_PC.
//  6 IFETCH_PERF_CNT_EN: 10 accepts + 4 stall cycles -> perf_fetched=10, perf_stalls=4; undefined -> both 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifetch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        ERR    = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_STEP    = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Saturating counter pair for fetch performance monitoring (accepts / stall cycles).
module ifetch_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_a,
    input  logic             inc_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic inc);
        if (inc && (val != {CNT_W{1'b1}})) begin
            return val + CNT_W'(1);
        end
        return val;
    endfunction

    always_comb begin
        cnt_a_d = sat_inc(cnt_a_q, inc_a);
        cnt_b_d = sat_inc(cnt_b_q, inc_b);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, pairs sync-ROM words with their PC for decode.
// Optional saturating perf counters when IFETCH_PERF_CNT_EN is defined.
module instr_fetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic [ADDR_W-1:0]  fetch_pc,
    output logic               halted,
    output logic               fetch_err,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] f2_pc_q, f2_pc_d;
    logic              f2_valid_q, f2_valid_d;
    logic              stall;
    logic              redir_bad;

    assign stall     = f2_valid_q & ~fetch_ready;
    assign redir_bad = redirect_valid & is_misaligned(redirect_pc[1:0]);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        f2_pc_d    = f2_pc_q;
        f2_valid_d = f2_valid_q;
        case (state_q)
            RUN: begin
                if (redir_bad) begin
                    state_d    = ERR;
                    f2_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    // Word in F2 is squashed; target is issued this same cycle.
                    f2_pc_d    = redirect_pc;
                    f2_valid_d = 1'b1;
                    pc_d       = redirect_pc + ADDR_W'(PC_STEP);
                end else if (stall) begin
                    state_d = RUN;
                end else if (halt_req) begin
                    state_d    = DRAIN;
                    f2_valid_d = 1'b0;
                end else begin
                    f2_pc_d    = pc_q;
                    f2_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(PC_STEP);
                end
            end
            DRAIN, HALTED: begin
                // While stopped a redirect only retargets the resume point.
                if (redir_bad) begin
                    state_d = ERR;
                end else begin
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
                    if (state_q == DRAIN) begin
                        state_d = HALTED;
                    end else if (!halt_req) begin
                        state_d = RUN;
                    end
                end
                f2_valid_d = 1'b0;
            end
            ERR: begin
                f2_valid_d = 1'b0;
            end
            default: begin
                state_d    = ERR;
                f2_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        imem_addr = pc_q;
        if (state_q == RUN) begin
            if (redirect_valid) begin
                imem_addr = redirect_pc;
            end else if (stall) begin
                // Re-read the held address so the ROM output stays stable.
                imem_addr = f2_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            f2_pc_q    <= '0;
            f2_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            f2_pc_q    <= f2_pc_d;
            f2_valid_q <= f2_valid_d;
        end
    end

    assign fetch_valid = f2_valid_q & ~redirect_valid & (state_q != ERR);
    assign fetch_pc    = f2_pc_q;
    assign fetch_instr = imem_rdata;
    assign halted      = (state_q == HALTED);
    assign fetch_err   = (state_q == ERR);

`ifdef IFETCH_PERF_CNT_EN
    logic accept;
    assign accept = fetch_valid & fetch_ready;

    ifetch_perf_cnt #(
        .CNT_W (32)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_a (accept),
        .inc_b (stall),
        .cnt_a (perf_fetched),
        .cnt_b (perf_stalls)
    );
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
`endif

endmodule
